// File: rtl/step_monitor.sv
// step_monitor: reduces a step-pulse stream and a 1 Hz tick into step,
// distance and per-second activity statistics for the display path.
module step_monitor #(
    parameter int STEP_MAX          = 9999,
    parameter int STEPS_PER_HALF_MI = 1024,
    parameter int FAST_THRESH       = 32,
    parameter int HI_THRESH         = 64,
    parameter int FAST_WINDOW       = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk1hz,
    input  logic        start,
    input  logic        pulse,
    output logic [13:0] step_count,
    output logic        step_ovf,
    output logic [3:0]  dist_half_mi,
    output logic [7:0]  sec_steps,
    output logic        sec_valid,
    output logic [3:0]  fast_secs,
    output logic [9:0]  hi_secs
);

    localparam int          SHIFT = $clog2(STEPS_PER_HALF_MI);
    localparam logic [13:0] SMAX  = 14'(STEP_MAX);
    localparam logic [7:0]  FTH   = 8'(FAST_THRESH);
    localparam logic [7:0]  HTH   = 8'(HI_THRESH);
    localparam logic [7:0]  FWIN  = 8'(FAST_WINDOW);

    logic       pulse_d, tick_d, start_d;
    logic       session;   // set by a start rise, cleared only by reset
    logic [7:0] cur_sec;
    logic [7:0] sec_idx;
    logic [7:0] n_sec;
    logic       step_ev, tick_ev, start_ev;

    assign step_ev  = pulse  & ~pulse_d;
    assign tick_ev  = clk1hz & ~tick_d;
    assign start_ev = start  & ~start_d;

    // distance is a pure shift of the registered total
    assign dist_half_mi = 4'(step_count >> SHIFT);

    // steps of the closing second, including a step coincident with the tick
    always_comb begin
        n_sec = cur_sec;
        if (step_ev && cur_sec != 8'hFF)
            n_sec = cur_sec + 8'd1;
    end

    // edge history, session tracking and all statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_d    <= pulse;
            tick_d     <= clk1hz;
            start_d    <= start;
            session    <= 1'b0;
            cur_sec    <= '0;
            sec_idx    <= '0;
            step_count <= '0;
            step_ovf   <= 1'b0;
            sec_steps  <= '0;
            sec_valid  <= 1'b0;
            fast_secs  <= '0;
            hi_secs    <= '0;
        end else begin
            pulse_d   <= pulse;
            tick_d    <= clk1hz;
            start_d   <= start;
            sec_valid <= 1'b0;
            if (start_ev) begin
                // coincident step/tick events are discarded on session start
                session    <= 1'b1;
                cur_sec    <= '0;
                sec_idx    <= '0;
                step_count <= '0;
                step_ovf   <= 1'b0;
                sec_steps  <= '0;
                fast_secs  <= '0;
                hi_secs    <= '0;
            end else if (start && session) begin
                if (step_ev) begin
                    cur_sec <= n_sec;
                    if (step_count == SMAX)
                        step_ovf <= 1'b1;
                    else
                        step_count <= step_count + 14'd1;
                end
                if (tick_ev) begin
                    sec_steps <= n_sec;
                    sec_valid <= 1'b1;
                    cur_sec   <= '0;
                    if (sec_idx != 8'hFF)
                        sec_idx <= sec_idx + 8'd1;
                    if (sec_idx < FWIN && n_sec > FTH)
                        fast_secs <= fast_secs + 4'd1;
                    if (n_sec >= HTH && hi_secs != 10'h3FF)
                        hi_secs <= hi_secs + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_step_monitor.sv
// tb_step_monitor: directed stimulus with a scoreboard of expected
// per-second reports, checked by an independent monitor on sec_valid.
module tb_step_monitor;

    logic        clk = 1'b0;
    logic        reset, clk1hz, start, pulse;
    logic [13:0] step_count;
    logic        step_ovf;
    logic [3:0]  dist_half_mi;
    logic [7:0]  sec_steps;
    logic        sec_valid;
    logic [3:0]  fast_secs;
    logic [9:0]  hi_secs;

    typedef struct {
        int ss;
        int fs;
        int hs;
        int sc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   done  = 1'b0;

    step_monitor dut (
        .clk(clk), .reset(reset), .clk1hz(clk1hz), .start(start), .pulse(pulse),
        .step_count(step_count), .step_ovf(step_ovf), .dist_half_mi(dist_half_mi),
        .sec_steps(sec_steps), .sec_valid(sec_valid), .fast_secs(fast_secs),
        .hi_secs(hi_secs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        pulse = 1'b1; cyc();
        pulse = 1'b0; cyc();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic tick(input bit with_step);
        clk1hz = 1'b1; pulse = with_step; cyc();
        clk1hz = 1'b0; pulse = 1'b0;      cyc();
    endtask

    task automatic expect_sec(input int ss, input int fs, input int hs, input int sc);
        exp_t e;
        e.ss = ss; e.fs = fs; e.hs = hs; e.sc = sc;
        q.push_back(e);
    endtask

    task automatic new_session();
        start = 1'b0; cyc();
        start = 1'b1; cyc();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_step_count"}, step_count, 0);
        chk({tag, "_step_ovf"}, step_ovf, 0);
        chk({tag, "_dist"}, dist_half_mi, 0);
        chk({tag, "_sec_steps"}, sec_steps, 0);
        chk({tag, "_sec_valid"}, sec_valid, 0);
        chk({tag, "_fast_secs"}, fast_secs, 0);
        chk({tag, "_hi_secs"}, hi_secs, 0);
    endtask

    // monitor: every sec_valid strobe must match the next expected report
    initial begin : monitor
        bit prev_v = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) break;
            if (sec_valid) begin
                chk("sec_valid_one_cycle", int'(prev_v), 0);
                if (q.size() == 0) begin
                    chk("unexpected_sec_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sec_steps", sec_steps, e.ss);
                    chk("fast_secs", fast_secs, e.fs);
                    chk("hi_secs", hi_secs, e.hs);
                    chk("step_count_at_tick", step_count, e.sc);
                end
            end
            prev_v = sec_valid;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int guard;
        reset = 1'b1; clk1hz = 1'b1; start = 1'b1; pulse = 1'b1;
        repeat (3) cyc();
        reset = 1'b0; cyc();
        chk_all_zero("reset");
        // held-high inputs at release are not events; no session either
        repeat (3) cyc();
        chk("held_pulse_no_step", step_count, 0);
        pulse = 1'b0; clk1hz = 1'b0; cyc();
        pulse = 1'b1; cyc();
        pulse = 1'b0; cyc();
        chk("no_session_after_reset", step_count, 0);

        // 40 steps then a tick
        new_session();
        steps(40);
        chk("step_count_40", step_count, 40);
        expect_sec(40, 1, 0, 40);
        tick(1'b0);

        // 63 steps plus one coincident with the tick -> 64
        steps(63);
        expect_sec(64, 2, 1, 104);
        tick(1'b1);
        // cur_sec cleared: empty second reports 0
        expect_sec(0, 2, 1, 104);
        tick(1'b0);

        // 12 seconds of 33 steps; only the first 9 count as fast
        new_session();
        for (int s = 1; s <= 12; s++) begin
            steps(33);
            expect_sec(33, (s < 9) ? s : 9, 0, 33 * s);
            tick(1'b0);
        end
        chk("step_count_396", step_count, 396);
        chk("dist_396", dist_half_mi, 0);

        // saturation
        new_session();
        for (int i = 1; i <= 10010; i++) begin
            step();
            if (i == 1023) chk("dist_1023", dist_half_mi, 0);
            if (i == 1024) chk("dist_1024", dist_half_mi, 1);
            if (i == 9999) begin
                chk("count_9999", step_count, 9999);
                chk("ovf_9999", step_ovf, 0);
            end
            if (i == 10000) begin
                chk("count_10000", step_count, 9999);
                chk("ovf_10000", step_ovf, 1);
            end
        end
        chk("count_10010", step_count, 9999);
        chk("ovf_10010", step_ovf, 1);
        chk("dist_sat", dist_half_mi, 9);
        // cur_sec saturated at 255 during this long second
        expect_sec(255, 1, 1, 9999);
        tick(1'b0);

        // idle hold, restart clear, mid-session reset
        new_session();
        steps(100);
        start = 1'b0; cyc();
        steps(5);
        tick(1'b0);
        chk("idle_hold_count", step_count, 100);
        chk("idle_hold_secs", sec_steps, 0);
        start = 1'b1; cyc();
        chk("restart_clear", step_count, 0);
        steps(10);
        chk("count_10", step_count, 10);
        pulse = 1'b1; reset = 1'b1; cyc();
        reset = 1'b0; pulse = 1'b0; cyc();
        chk_all_zero("midreset");
        step();
        tick(1'b1);
        chk("post_reset_no_count", step_count, 0);

        guard = 0;
        while (q.size() != 0 && guard < 20) begin cyc(); guard++; end
        chk("queue_drain", q.size(), 0);
        cyc();
        done = 1'b1;
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
